axi4lite_arb2: RTL and testbench

Two-requester AXI4-Lite arbiter that shares one `axi4lite_slave` between two AXI4-Lite masters, such as a CPU bridge and a DMA/test master. It sits directly in front of the slave, with upstream ports S[1:0] and one downstream port M. It serializes all traffic to one transaction in flight, with round-robin fairness between requesters. The channel set matches the slave: no PROT, no STRB.

---
 rtl/axi4lite_pkg.sv | 18 +
 rtl/axi4lite_arb2_if.sv | 50 +++++
 rtl/axi4lite_rr_arb2.sv | 15 +
 rtl/axi4lite_arb2.sv | 162 ++++++++++++++++
 tb/tb_axi4lite_arb2.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4lite_pkg.sv
// Shared constants and FSM state type for the two-requester AXI4-Lite arbiter.
package axi4lite_pkg;
  localparam int AXI_ADDR_WIDTH_DEF = 32;
  localparam int AXI_DATA_WIDTH_DEF = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } arb_state_t;
endpackage

// File: rtl/axi4lite_arb2_if.sv
// Bundle of the two upstream AXI4-Lite ports (S, packed [1:0]) and the downstream port (M).
interface axi4lite_arb2_if
  import axi4lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF
);
  // Every channel transfers on a rising edge where VALID and READY are both high; a
  // source holds VALID and its payload steady until that edge and never withdraws it.
  logic [1:0]                     S_AW_VALID, S_W_VALID, S_AR_VALID, S_B_READY, S_R_READY;
  logic [1:0][AXI_ADDR_WIDTH-1:0] S_AW_ADDR, S_AR_ADDR;
  logic [1:0][AXI_DATA_WIDTH-1:0] S_W_DATA;
  logic [1:0]                     S_AW_READY, S_W_READY, S_AR_READY, S_B_VALID, S_R_VALID;
  logic [1:0][1:0]                S_B_RESP, S_R_RESP;
  logic [1:0][AXI_DATA_WIDTH-1:0] S_R_DATA;

  logic                      M_AW_VALID, M_W_VALID, M_AR_VALID, M_B_READY, M_R_READY;
  logic [AXI_ADDR_WIDTH-1:0] M_AW_ADDR, M_AR_ADDR;
  logic [AXI_DATA_WIDTH-1:0] M_W_DATA;
  logic                      M_AW_READY, M_W_READY, M_AR_READY, M_B_VALID, M_R_VALID;
  logic [1:0]                M_B_RESP, M_R_RESP;
  logic [AXI_DATA_WIDTH-1:0] M_R_DATA;

  logic GRANT, BUSY;

  // slave: the arbiter's view; master: the surrounding masters and downstream slave.
  modport slave (
    input  S_AW_VALID, S_W_VALID, S_AR_VALID, S_B_READY, S_R_READY,
    input  S_AW_ADDR, S_AR_ADDR, S_W_DATA,
    output S_AW_READY, S_W_READY, S_AR_READY, S_B_VALID, S_R_VALID,
    output S_B_RESP, S_R_RESP, S_R_DATA,
    output M_AW_VALID, M_W_VALID, M_AR_VALID, M_B_READY, M_R_READY,
    output M_AW_ADDR, M_AR_ADDR, M_W_DATA,
    input  M_AW_READY, M_W_READY, M_AR_READY, M_B_VALID, M_R_VALID,
    input  M_B_RESP, M_R_RESP, M_R_DATA,
    output GRANT, BUSY
  );

  modport master (
    output S_AW_VALID, S_W_VALID, S_AR_VALID, S_B_READY, S_R_READY,
    output S_AW_ADDR, S_AR_ADDR, S_W_DATA,
    input  S_AW_READY, S_W_READY, S_AR_READY, S_B_VALID, S_R_VALID,
    input  S_B_RESP, S_R_RESP, S_R_DATA,
    input  M_AW_VALID, M_W_VALID, M_AR_VALID, M_B_READY, M_R_READY,
    input  M_AW_ADDR, M_AR_ADDR, M_W_DATA,
    output M_AW_READY, M_W_READY, M_AR_READY, M_B_VALID, M_R_VALID,
    output M_B_RESP, M_R_RESP, M_R_DATA,
    input  GRANT, BUSY
  );
endinterface

// File: rtl/axi4lite_rr_arb2.sv
// Combinational 2-way round-robin pick: on a tie the requester that did not win last goes.
module axi4lite_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);
  assign grant_valid = |req;

  always_comb begin
    grant_idx = 1'b0;
    if (req[0] && req[1]) grant_idx = ~last_grant;
    else                  grant_idx = req[1];
  end
endmodule

// File: rtl/axi4lite_arb2.sv
// Two-requester AXI4-Lite arbiter: one transaction in flight, round-robin between S0/S1.
// The FSM only tracks ownership; every channel is a combinational pass-through to the owner.
module axi4lite_arb2
  import axi4lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF
) (
  input  logic           A_CLK,
  input  logic           A_RST,
  axi4lite_arb2_if.slave bus,
  output arb_state_t     dbg_state
);
  arb_state_t state;
  logic       g, last_grant, busy, aw_done, w_done;
  logic [1:0] wreq, rreq, req;
  logic       grant_valid, grant_idx;
  logic       aw_hs, w_hs, ar_hs, b_hs, r_hs;

  logic [1:0]                     s_aw_ready, s_w_ready, s_ar_ready, s_b_valid, s_r_valid;
  logic [1:0][1:0]                s_b_resp, s_r_resp;
  logic [1:0][AXI_DATA_WIDTH-1:0] s_r_data;
  logic                           m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready;
  logic [AXI_ADDR_WIDTH-1:0]      m_aw_addr, m_ar_addr;
  logic [AXI_DATA_WIDTH-1:0]      m_w_data;

  assign wreq = bus.S_AW_VALID & bus.S_W_VALID;
  assign rreq = bus.S_AR_VALID;
  assign req  = wreq | rreq;

  axi4lite_rr_arb2 u_rr (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign aw_hs = m_aw_valid & bus.M_AW_READY;
  assign w_hs  = m_w_valid  & bus.M_W_READY;
  assign ar_hs = m_ar_valid & bus.M_AR_READY;
  assign b_hs  = bus.M_B_VALID & m_b_ready;
  assign r_hs  = bus.M_R_VALID & m_r_ready;

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      state      <= IDLE;
      g          <= 1'b0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          g     <= grant_idx;
          busy  <= 1'b1;
          state <= wreq[grant_idx] ? WR_ADDR : RD_ADDR;
        end
        // AW and W may complete in either order; the flags stop a second issue.
        WR_ADDR: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_RESP;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: if (b_hs) begin
          last_grant <= g;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        RD_ADDR: if (ar_hs) state <= RD_DATA;
        RD_DATA: if (r_hs) begin
          last_grant <= g;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    s_aw_ready = '0;
    s_w_ready  = '0;
    s_ar_ready = '0;
    s_b_valid  = '0;
    s_r_valid  = '0;
    s_b_resp   = '0;
    s_r_resp   = '0;
    s_r_data   = '0;
    m_aw_valid = 1'b0;
    m_w_valid  = 1'b0;
    m_ar_valid = 1'b0;
    m_b_ready  = 1'b0;
    m_r_ready  = 1'b0;
    m_aw_addr  = '0;
    m_ar_addr  = '0;
    m_w_data   = '0;
    case (state)
      WR_ADDR: begin
        m_aw_valid    = bus.S_AW_VALID[g] & ~aw_done;
        m_w_valid     = bus.S_W_VALID[g] & ~w_done;
        m_aw_addr     = bus.S_AW_ADDR[g];
        m_w_data      = bus.S_W_DATA[g];
        s_aw_ready[g] = bus.M_AW_READY & ~aw_done;
        s_w_ready[g]  = bus.M_W_READY & ~w_done;
      end
      WR_RESP: begin
        s_b_valid[g] = bus.M_B_VALID;
        s_b_resp[g]  = bus.M_B_RESP;
        m_b_ready    = bus.S_B_READY[g];
      end
      RD_ADDR: begin
        m_ar_valid    = bus.S_AR_VALID[g];
        m_ar_addr     = bus.S_AR_ADDR[g];
        s_ar_ready[g] = bus.M_AR_READY;
      end
      RD_DATA: begin
        s_r_valid[g] = bus.M_R_VALID;
        s_r_data[g]  = bus.M_R_DATA;
        s_r_resp[g]  = bus.M_R_RESP;
        m_r_ready    = bus.S_R_READY[g];
      end
      default: ;
    endcase
  end

  assign bus.S_AW_READY = s_aw_ready;
  assign bus.S_W_READY  = s_w_ready;
  assign bus.S_AR_READY = s_ar_ready;
  assign bus.S_B_VALID  = s_b_valid;
  assign bus.S_R_VALID  = s_r_valid;
  assign bus.S_B_RESP   = s_b_resp;
  assign bus.S_R_RESP   = s_r_resp;
  assign bus.S_R_DATA   = s_r_data;
  assign bus.M_AW_VALID = m_aw_valid;
  assign bus.M_W_VALID  = m_w_valid;
  assign bus.M_AR_VALID = m_ar_valid;
  assign bus.M_B_READY  = m_b_ready;
  assign bus.M_R_READY  = m_r_ready;
  assign bus.M_AW_ADDR  = m_aw_addr;
  assign bus.M_AR_ADDR  = m_ar_addr;
  assign bus.M_W_DATA   = m_w_data;
  assign bus.GRANT      = g;
  assign bus.BUSY       = busy;
  assign dbg_state      = state;

  // A granted requester withdrawing VALID before its handshake is unsupported.
  a_aw_hold: assert property (@(posedge A_CLK) disable iff (A_RST)
    (state == WR_ADDR && !aw_done) |-> bus.S_AW_VALID[g]);
  a_w_hold: assert property (@(posedge A_CLK) disable iff (A_RST)
    (state == WR_ADDR && !w_done) |-> bus.S_W_VALID[g]);
  a_ar_hold: assert property (@(posedge A_CLK) disable iff (A_RST)
    (state == RD_ADDR) |-> bus.S_AR_VALID[g]);
endmodule

// File: tb/tb_axi4lite_arb2.sv
// Bench for axi4lite_arb2: two driven upstream masters, a small memory slave model,
// and a scoreboard of expected responses and grant order checked by a negedge monitor.
module tb_axi4lite_arb2;
  import axi4lite_pkg::*;

  logic       clk, rst;
  arb_state_t dbg_state;
  int         tests, failed;

  logic [34:0] exp_q0[$];
  logic [34:0] exp_q1[$];
  logic        grant_q[$];
  logic        busy_d, exp_g;

  axi4lite_arb2_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

  axi4lite_arb2 #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .A_CLK     (clk),
    .A_RST     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic [31:0] mem [16];
  logic        s_aw_got, s_w_got, s_b_valid, s_r_valid, stall_w;
  logic [31:0] s_aw_addr, s_w_data, s_r_data, wa, wd, ra;
  logic [1:0]  s_r_resp;
  int          s_since_aw, aw_cnt;
  logic        aw_hs_m, w_hs_m, ar_hs_m;

  assign bus.M_AW_READY = !s_aw_got && !s_b_valid;
  assign bus.M_W_READY  = !s_w_got && !s_b_valid && (!stall_w || (s_aw_got && s_since_aw >= 1));
  assign bus.M_AR_READY = !s_r_valid;
  assign bus.M_B_VALID  = s_b_valid;
  assign bus.M_B_RESP   = RESP_OKAY;
  assign bus.M_R_VALID  = s_r_valid;
  assign bus.M_R_DATA   = s_r_data;
  assign bus.M_R_RESP   = s_r_resp;

  assign aw_hs_m = bus.M_AW_VALID && bus.M_AW_READY;
  assign w_hs_m  = bus.M_W_VALID && bus.M_W_READY;
  assign ar_hs_m = bus.M_AR_VALID && bus.M_AR_READY;
  assign wa      = s_aw_got ? s_aw_addr : bus.M_AW_ADDR;
  assign wd      = s_w_got ? s_w_data : bus.M_W_DATA;
  assign ra      = bus.M_AR_ADDR;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) mem[k] <= '0;
      s_aw_got   <= 1'b0;
      s_w_got    <= 1'b0;
      s_b_valid  <= 1'b0;
      s_r_valid  <= 1'b0;
      s_since_aw <= 0;
      s_aw_addr  <= '0;
      s_w_data   <= '0;
      s_r_data   <= '0;
      s_r_resp   <= RESP_OKAY;
    end else begin
      if (aw_hs_m) begin
        s_aw_got  <= 1'b1;
        s_aw_addr <= bus.M_AW_ADDR;
        aw_cnt    <= aw_cnt + 1;
      end
      if (w_hs_m) begin
        s_w_got  <= 1'b1;
        s_w_data <= bus.M_W_DATA;
      end
      if (s_aw_got) s_since_aw <= s_since_aw + 1;
      if ((s_aw_got || aw_hs_m) && (s_w_got || w_hs_m)) begin
        mem[wa[3:0]] <= wd;
        s_b_valid    <= 1'b1;
        s_aw_got     <= 1'b0;
        s_w_got      <= 1'b0;
        s_since_aw   <= 0;
      end
      if (s_b_valid && bus.M_B_READY) s_b_valid <= 1'b0;
      if (ar_hs_m) begin
        s_r_valid <= 1'b1;
        s_r_data  <= (ra[31:4] == '0) ? mem[ra[3:0]] : 32'h0;
        s_r_resp  <= (ra[31:4] == '0) ? RESP_OKAY : RESP_SLVERR;
      end
      if (s_r_valid && bus.M_R_READY) s_r_valid <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input int i, input logic [34:0] item);
    if (i == 0) exp_q0.push_back(item);
    else        exp_q1.push_back(item);
  endtask

  task automatic sb_pop(input int i, input logic [34:0] act);
    logic [34:0] exp;
    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
      tests++;
      failed++;
      $display("FAIL unexpected_resp_s%0d: got %0h expected none", i, act);
    end else begin
      if (i == 0) exp = exp_q0.pop_front();
      else        exp = exp_q1.pop_front();
      check($sformatf("resp_s%0d", i), {29'h0, act}, {29'h0, exp});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      busy_d = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.S_B_VALID[i] && bus.S_B_READY[i]) sb_pop(i, {1'b1, bus.S_B_RESP[i], 32'h0});
        if (bus.S_R_VALID[i] && bus.S_R_READY[i]) sb_pop(i, {1'b0, bus.S_R_RESP[i], bus.S_R_DATA[i]});
        if (!bus.BUSY || int'(bus.GRANT) != i)
          check($sformatf("isolate_s%0d", i),
                {23'h0, bus.S_AW_READY[i], bus.S_W_READY[i], bus.S_AR_READY[i], bus.S_B_VALID[i],
                 bus.S_R_VALID[i], bus.S_B_RESP[i], bus.S_R_RESP[i], bus.S_R_DATA[i]}, 64'h0);
      end
      if (!bus.BUSY) begin
        check("idle_m_hs", {59'h0, bus.M_AW_VALID, bus.M_W_VALID, bus.M_AR_VALID,
                            bus.M_B_READY, bus.M_R_READY}, 64'h0);
        check("idle_m_bus", {63'h0, (|bus.M_AW_ADDR) | (|bus.M_AR_ADDR) | (|bus.M_W_DATA)}, 64'h0);
      end
      if (bus.BUSY && !busy_d) begin
        if (grant_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_grant: got %0d expected none", bus.GRANT);
        end else begin
          exp_g = grant_q.pop_front();
          check("grant", {63'h0, bus.GRANT}, {63'h0, exp_g});
        end
      end
      busy_d = bus.BUSY;
    end
  end

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    bus.S_AW_VALID = '0;
    bus.S_W_VALID  = '0;
    bus.S_AR_VALID = '0;
    bus.S_B_READY  = '0;
    bus.S_R_READY  = '0;
    bus.S_AW_ADDR  = '0;
    bus.S_AR_ADDR  = '0;
    bus.S_W_DATA   = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    clear_inputs();
    #2;
    rst = 1'b0;
  endtask

  task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d);
    logic aw_pend, w_pend, aw_hs, w_hs, b_seen;
    int   n;
    exp_push(i, {1'b1, RESP_OKAY, 32'h0});
    @(posedge clk);
    #1;
    bus.S_AW_ADDR[i]  = a;
    bus.S_W_DATA[i]   = d;
    bus.S_AW_VALID[i] = 1'b1;
    bus.S_W_VALID[i]  = 1'b1;
    bus.S_B_READY[i]  = 1'b1;
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    b_seen  = 1'b0;
    n       = 0;
    while (!b_seen && n < 100) begin
      @(negedge clk);
      aw_hs  = aw_pend && bus.S_AW_READY[i];
      w_hs   = w_pend && bus.S_W_READY[i];
      b_seen = bus.S_B_VALID[i];
      @(posedge clk);
      #1;
      if (aw_hs) begin bus.S_AW_VALID[i] = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin bus.S_W_VALID[i]  = 1'b0; w_pend  = 1'b0; end
      n++;
    end
    bus.S_B_READY[i] = 1'b0;
    check($sformatf("wr_done_s%0d", i), {63'h0, b_seen}, 64'h1);
  endtask

  task automatic do_read(input int i, input logic [31:0] a, input logic [1:0] resp,
                         input logic [31:0] d);
    logic ar_pend, ar_hs, r_seen;
    int   n;
    exp_push(i, {1'b0, resp, d});
    @(posedge clk);
    #1;
    bus.S_AR_ADDR[i]  = a;
    bus.S_AR_VALID[i] = 1'b1;
    bus.S_R_READY[i]  = 1'b1;
    ar_pend = 1'b1;
    r_seen  = 1'b0;
    n       = 0;
    while (!r_seen && n < 100) begin
      @(negedge clk);
      ar_hs  = ar_pend && bus.S_AR_READY[i];
      r_seen = bus.S_R_VALID[i];
      @(posedge clk);
      #1;
      if (ar_hs) begin bus.S_AR_VALID[i] = 1'b0; ar_pend = 1'b0; end
      n++;
    end
    bus.S_R_READY[i] = 1'b0;
    check($sformatf("rd_done_s%0d", i), {63'h0, r_seen}, 64'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic got, hs;
    int   aw_base;
    tests   = 0;
    failed  = 0;
    stall_w = 1'b0;
    aw_cnt  = 0;
    busy_d  = 1'b0;
    rst     = 1'b0;
    clear_inputs();

    // Reset window 2..12 ns; outputs must be quiet inside it and one cycle after.
    #2 rst = 1'b1;
    #5;
    check("rst_s_hs", {54'h0, bus.S_AW_READY, bus.S_W_READY, bus.S_AR_READY,
                       bus.S_B_VALID, bus.S_R_VALID}, 64'h0);
    check("rst_m_hs", {59'h0, bus.M_AW_VALID, bus.M_W_VALID, bus.M_AR_VALID,
                       bus.M_B_READY, bus.M_R_READY}, 64'h0);
    check("rst_busy", {63'h0, bus.BUSY}, 64'h0);
    check("rst_grant", {63'h0, bus.GRANT}, 64'h0);
    #5 rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_hs", {54'h0, bus.S_AW_READY, bus.S_W_READY, bus.S_AR_READY,
                            bus.S_B_VALID, bus.S_R_VALID}, 64'h0);
    check("post_rst_busy", {63'h0, bus.BUSY}, 64'h0);
    check("post_rst_state", {61'h0, dbg_state}, {61'h0, IDLE});

    // S0 write then read back.
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b0);
    do_write(0, 32'h1, 32'h1);
    do_read(0, 32'h1, RESP_OKAY, 32'h1);

    // Competing reads alternate; S1's last read hits an unmapped address.
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    do_write(0, 32'h3, 32'h33);
    do_write(1, 32'h4, 32'h44);
    for (int k = 0; k < 4; k++) begin
      grant_q.push_back(1'b0);
      grant_q.push_back(1'b1);
    end
    fork
      begin
        for (int k = 0; k < 4; k++) do_read(0, 32'h4, RESP_OKAY, 32'h44);
      end
      begin
        for (int k = 0; k < 3; k++) do_read(1, 32'h3, RESP_OKAY, 32'h33);
        do_read(1, 32'h100, RESP_SLVERR, 32'h0);
      end
    join

    // After reset the tie goes to S0's read, then S1's write, then S0 sees the new data.
    pulse_reset();
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    grant_q.push_back(1'b0);
    fork
      do_read(0, 32'h2, RESP_OKAY, 32'h0);
      do_write(1, 32'h2, 32'hA5);
    join
    do_read(0, 32'h2, RESP_OKAY, 32'hA5);

    // Slave takes W two cycles after AW.
    stall_w = 1'b1;
    aw_base = aw_cnt;
    grant_q.push_back(1'b1);
    fork
      do_write(1, 32'h6, 32'h66);
      begin
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
          @(negedge clk);
          got = bus.M_AW_VALID && bus.M_AW_READY;
        end
        check("stall_aw_seen", {63'h0, got}, 64'h1);
        @(negedge clk);
        check("stall_state", {61'h0, dbg_state}, {61'h0, WR_ADDR});
        check("stall_no_reissue", {63'h0, bus.M_AW_VALID}, 64'h0);
        check("stall_w_waiting", {63'h0, bus.M_W_VALID && !bus.M_W_READY}, 64'h1);
      end
    join
    stall_w = 1'b0;
    check("stall_aw_count", 64'(aw_cnt - aw_base), 64'h1);
    grant_q.push_back(1'b1);
    do_read(1, 32'h6, RESP_OKAY, 32'h66);

    // Reset while RD_DATA holds M_R_VALID with the requester not ready.
    grant_q.push_back(1'b0);
    @(posedge clk);
    #1;
    bus.S_AR_ADDR[0]  = 32'h1;
    bus.S_AR_VALID[0] = 1'b1;
    bus.S_R_READY[0]  = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dbg_state == RD_DATA && bus.M_R_VALID) begin got = 1'b1; break; end
      hs = bus.S_AR_READY[0];
      @(posedge clk);
      #1;
      if (hs) bus.S_AR_VALID[0] = 1'b0;
    end
    check("mid_rst_reach", {63'h0, got}, 64'h1);
    check("mid_rst_rvalid_pre", {63'h0, bus.S_R_VALID[0]}, 64'h1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_state", {61'h0, dbg_state}, {61'h0, IDLE});
    check("mid_rst_rvalid", {62'h0, bus.S_R_VALID}, 64'h0);
    check("mid_rst_busy", {63'h0, bus.BUSY}, 64'h0);
    clear_inputs();
    #2 rst = 1'b0;
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b0);
    do_write(0, 32'h5, 32'h5A);
    do_read(0, 32'h5, RESP_OKAY, 32'h5A);

    repeat (5) @(negedge clk);
    check("q0_empty", 64'(exp_q0.size()), 64'h0);
    check("q1_empty", 64'(exp_q1.size()), 64'h0);
    check("grant_q_empty", 64'(grant_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
